// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit (FSM states, funct3 codes,
// mem_sel bit positions, exception causes) plus the load lane-extraction helper.
package lsu_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int SEL_LB  = 7;
   localparam int SEL_LBU = 6;
   localparam int SEL_LH  = 5;
   localparam int SEL_LHU = 4;
   localparam int SEL_LW  = 3;
   localparam int SEL_SB  = 2;
   localparam int SEL_SH  = 1;
   localparam int SEL_SW  = 0;

   localparam logic [3:0] CAUSE_NONE        = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

   localparam logic [2:0] MEM_STATE_ACCESS = 3'd3;

   // Memory returns the whole word; pick the lane by the low address bits and extend.
   function automatic logic [31:0] load_extract(input logic [7:0] sel, input logic [1:0] off, input logic [31:0] word);
      logic [31:0] s;
      s = word >> {off, 3'b000};
      return sel[SEL_LB]  ? {{24{s[7]}}, s[7:0]} :
             sel[SEL_LBU] ? {24'h0, s[7:0]} :
             sel[SEL_LH]  ? {{16{s[15]}}, s[15:0]} :
             sel[SEL_LHU] ? {16'h0, s[15:0]} : word;
   endfunction
endpackage

// File: rtl/lsu_decode.sv
// lsu_decode: maps load/store/funct3 and the low address bits to a one-hot
// mem_sel, an illegal-request flag and a misaligned flag.
module lsu_decode
   import lsu_pkg::*;
(
   input  logic       load,
   input  logic       store,
   input  logic [2:0] funct3,
   input  logic [1:0] addr_lo,
   output logic [7:0] sel,
   output logic       illegal,
   output logic       misaligned
);
   always_comb begin
      sel = '0;
      if (load && !store)
         case (funct3)
            F3_B:    sel[SEL_LB]  = 1'b1;
            F3_H:    sel[SEL_LH]  = 1'b1;
            F3_W:    sel[SEL_LW]  = 1'b1;
            F3_BU:   sel[SEL_LBU] = 1'b1;
            F3_HU:   sel[SEL_LHU] = 1'b1;
            default: ;
         endcase
      else if (store && !load)
         case (funct3)
            F3_B:    sel[SEL_SB] = 1'b1;
            F3_H:    sel[SEL_SH] = 1'b1;
            F3_W:    sel[SEL_SW] = 1'b1;
            default: ;
         endcase
      illegal = sel == '0;
      misaligned = ((sel[SEL_LH] | sel[SEL_LHU] | sel[SEL_SH]) & addr_lo[0]) |
                   ((sel[SEL_LW] | sel[SEL_SW]) & (addr_lo != 2'b00));
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-request-at-a-time LSU between execute, a synchronous data memory
// and writeback. Define LSU_ALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [2:0]  mem_state,
   output logic        mem_enabled,
   output logic        mem_load_enable,
   output logic        mem_store_enable,
   output logic [7:0]  mem_sel,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        exc_valid,
   output logic [3:0]  exc_cause,
   output logic [31:0] exc_tval
);
`ifdef LSU_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif
   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q, wb_data_q, exc_tval_q;
   logic [4:0]  rd_q;
   logic [7:0]  sel_q, dec_sel;
   logic [3:0]  exc_cause_q, cause;
   logic        load_q, store_q, wb_we_q, exc_q;
   logic        dec_illegal, dec_misaligned, misaligned, out_of_range, fault, fire, access;

   lsu_decode u_decode (
      .load       (req_load),
      .store      (req_store),
      .funct3     (req_funct3),
      .addr_lo    (req_addr[1:0]),
      .sel        (dec_sel),
      .illegal    (dec_illegal),
      .misaligned (dec_misaligned)
   );

   // Faults are classified at acceptance so they can skip the memory entirely.
   always_comb begin
      fire = req_valid && state == S_IDLE;
      misaligned = ALIGN_CHECK && dec_misaligned;
      out_of_range = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
      fault = dec_illegal || misaligned || out_of_range;
      cause = dec_illegal ? CAUSE_ILLEGAL :
              misaligned ? (req_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN) :
              out_of_range ? (req_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT) : CAUSE_NONE;
   end

   always_ff @(posedge clk)
      state <= rst ? S_IDLE : state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    state_nx = fire ? (fault ? S_RESP : S_ACCESS) : S_IDLE;
         S_ACCESS:  state_nx = load_q ? S_CAPTURE : S_RESP;
         S_CAPTURE: state_nx = S_RESP;
         S_RESP:    state_nx = wb_ready ? S_IDLE : S_RESP;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         sel_q       <= '0;
         load_q      <= 1'b0;
         store_q     <= 1'b0;
         wb_data_q   <= '0;
         wb_we_q     <= 1'b0;
         exc_q       <= 1'b0;
         exc_cause_q <= '0;
         exc_tval_q  <= '0;
      end else if (fire) begin
         addr_q      <= req_addr;
         wdata_q     <= req_wdata;
         rd_q        <= req_rd;
         sel_q       <= fault ? 8'h00 : dec_sel;
         load_q      <= req_load;
         store_q     <= req_store;
         wb_data_q   <= '0;
         wb_we_q     <= 1'b0;
         exc_q       <= fault;
         exc_cause_q <= cause;
         exc_tval_q  <= (fault && !dec_illegal) ? req_addr : 32'h0;
      end else if (state == S_CAPTURE) begin
         wb_data_q <= load_extract(sel_q, addr_q[1:0], mem_data_out);
         wb_we_q   <= 1'b1;
      end

   // Enables are gated by rst so a store caught mid-access never reaches memory.
   always_comb begin
      access = state == S_ACCESS;
      req_ready = state == S_IDLE;
      mem_state = access ? MEM_STATE_ACCESS : 3'd0;
      mem_enabled = access && !rst;
      mem_load_enable = access && load_q && !rst;
      mem_store_enable = access && store_q && !rst;
      mem_sel = access ? sel_q : 8'h00;
      mem_address = access ? addr_q : 32'h0;
      mem_data_in = access ? wdata_q : 32'h0;
      wb_valid = state == S_RESP;
      wb_we = wb_we_q;
      wb_rd = rd_q;
      wb_data = wb_data_q;
      exc_valid = wb_valid && exc_q;
      exc_cause = exc_cause_q;
      exc_tval = exc_tval_q;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for stall and reset,
// against a byte-lane synchronous memory model.
module tb_load_store_unit;
`ifdef LSU_ALIGN_CHECK_EN
   localparam bit ALN = 1'b1;
`else
   localparam bit ALN = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1, init = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_load = 1'b0, req_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic [2:0]  mem_state;
   logic        mem_enabled, mem_load_enable, mem_store_enable;
   logic [7:0]  mem_sel;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        wb_valid, wb_ready = 1'b1, wb_we, exc_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, exc_tval;
   logic [3:0]  exc_cause;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(1024)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_state(mem_state), .mem_enabled(mem_enabled), .mem_load_enable(mem_load_enable),
      .mem_store_enable(mem_store_enable), .mem_sel(mem_sel), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
   );

   // Synchronous memory: full word out the cycle after access; stores placed by sel and address.
   logic [31:0] mem [0:1023];
   logic [31:0] rdata = '0, wmask;
   logic [9:0]  widx;
   always_comb begin
      widx = mem_address[11:2];
      wmask = (mem_sel[2] ? 32'h0000_00FF : mem_sel[1] ? 32'h0000_FFFF : 32'hFFFF_FFFF) << {mem_address[1:0], 3'b000};
   end
   assign mem_data_out = rdata;
   always @(posedge clk)
      if (init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         mem[4] <= 32'hDEAD_BEEF;
         mem[5] <= 32'h5566_7788;
         mem[8] <= 32'h1122_3344;
         mem[10] <= 32'h0102_0304;
         mem[1023] <= 32'h0BAD_F00D;
      end else begin
         if (mem_load_enable) rdata <= mem[widx];
         if (mem_store_enable)
            mem[widx] <= (mem[widx] & ~wmask) | ((mem_data_in << {mem_address[1:0], 3'b000}) & wmask);
      end

   typedef struct {
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      logic [4:0]  rd;
      int          lat;
      logic        acc;
      logic [7:0]  sel;
      logic        we;
      logic [31:0] data;
      logic        exc;
      logic [3:0]  cause;
      logic [31:0] tval;
   } vec_t;

   function automatic vec_t vld(logic [2:0] f3, logic [31:0] a, logic [4:0] rd, logic [7:0] sel, logic [31:0] d);
      return '{1'b1, 1'b0, f3, a, 32'h0, rd, 3, 1'b1, sel, 1'b1, d, 1'b0, 4'd0, 32'h0};
   endfunction
   function automatic vec_t vst(logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [7:0] sel);
      return '{1'b0, 1'b1, f3, a, wd, 5'd2, 2, 1'b1, sel, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0};
   endfunction
   function automatic vec_t vflt(logic ld, logic st, logic [2:0] f3, logic [31:0] a, logic [3:0] c, logic [31:0] tv);
      return '{ld, st, f3, a, 32'h0, 5'd17, 1, 1'b0, 8'h00, 1'b0, 32'h0, 1'b1, c, tv};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic start(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      @(negedge clk);
      req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
      req_addr = a; req_wdata = wd; req_rd = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      int lat, acc;
      logic [7:0] sel_seen;
      start(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
      lat = 1; acc = 0; sel_seen = 8'h00;
      while (!wb_valid && lat < 8) begin
         if (mem_enabled) begin acc++; sel_seen = mem_sel; end
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("v%0d latency", k), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d access_cycles", k), 32'(acc), {31'h0, v.acc});
      if (v.acc) chk($sformatf("v%0d mem_sel", k), {24'h0, sel_seen}, {24'h0, v.sel});
      chk($sformatf("v%0d wb_we", k), {31'h0, wb_we}, {31'h0, v.we});
      chk($sformatf("v%0d wb_data", k), wb_data, v.data);
      chk($sformatf("v%0d wb_rd", k), {27'h0, wb_rd}, {27'h0, v.rd});
      chk($sformatf("v%0d exc_valid", k), {31'h0, exc_valid}, {31'h0, v.exc});
      if (v.exc) begin
         chk($sformatf("v%0d exc_cause", k), {28'h0, exc_cause}, {28'h0, v.cause});
         chk($sformatf("v%0d exc_tval", k), exc_tval, v.tval);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d back_to_idle", k), {30'h0, wb_valid, req_ready}, 32'h1);
   endtask

   vec_t vecs [$];

   initial begin
      vecs.push_back(vld(3'b010, 32'h10, 5'd5, 8'h08, 32'hDEAD_BEEF));
      vecs.push_back(vst(3'b010, 32'h10, 32'h80FF_0000, 8'h01));
      vecs.push_back(vld(3'b000, 32'h13, 5'd1, 8'h80, 32'hFFFF_FF80));
      vecs.push_back(vld(3'b100, 32'h13, 5'd2, 8'h40, 32'h0000_0080));
      vecs.push_back(vld(3'b001, 32'h12, 5'd3, 8'h20, 32'hFFFF_80FF));
      vecs.push_back(vld(3'b101, 32'h12, 5'd4, 8'h10, 32'h0000_80FF));
      vecs.push_back(vld(3'b000, 32'h10, 5'd6, 8'h80, 32'h0000_0000));
      vecs.push_back(vst(3'b001, 32'h16, 32'h1234_ABCD, 8'h02));
      vecs.push_back(vld(3'b010, 32'h14, 5'd8, 8'h08, 32'hABCD_7788));
      vecs.push_back(vst(3'b000, 32'h19, 32'h7777_77AA, 8'h04));
      vecs.push_back(vld(3'b010, 32'h18, 5'd10, 8'h08, 32'h0000_AA00));
      vecs.push_back(vld(3'b010, 32'hFFC, 5'd31, 8'h08, 32'h0BAD_F00D));
      vecs.push_back(vflt(1'b1, 1'b0, 3'b011, 32'h40, 4'd2, 32'h0));
      vecs.push_back(vflt(1'b1, 1'b1, 3'b010, 32'h10, 4'd2, 32'h0));
      vecs.push_back(vflt(1'b0, 1'b0, 3'b010, 32'h10, 4'd2, 32'h0));
      vecs.push_back(vflt(1'b0, 1'b1, 3'b100, 32'h10, 4'd2, 32'h0));
      vecs.push_back(vflt(1'b1, 1'b0, 3'b010, 32'h1000, 4'd5, 32'h1000));
      vecs.push_back(vflt(1'b0, 1'b1, 3'b010, 32'h1000, 4'd7, 32'h1000));
      vecs.push_back(vflt(1'b1, 1'b0, 3'b111, 32'h2000, 4'd2, 32'h0));
      vecs.push_back(vflt(1'b1, 1'b0, 3'b011, 32'h22, 4'd2, 32'h0));
      vecs.push_back(ALN ? vflt(1'b1, 1'b0, 3'b010, 32'h22, 4'd4, 32'h22) : vld(3'b010, 32'h22, 5'd11, 8'h08, 32'h1122_3344));
      vecs.push_back(ALN ? vflt(1'b0, 1'b1, 3'b001, 32'h21, 4'd6, 32'h21) : vst(3'b001, 32'h21, 32'h0000_BEEF, 8'h02));
      vecs.push_back(vld(3'b010, 32'h20, 5'd12, 8'h08, ALN ? 32'h1122_3344 : 32'h11BE_EF44));
      vecs.push_back(vflt(1'b1, 1'b0, 3'b010, 32'h1002, ALN ? 4'd4 : 4'd5, 32'h1002));
      vecs.push_back(vflt(1'b0, 1'b1, 3'b010, 32'h1001, ALN ? 4'd6 : 4'd7, 32'h1001));
      vecs.push_back(ALN ? vflt(1'b1, 1'b0, 3'b001, 32'h13, 4'd4, 32'h13) : vld(3'b001, 32'h13, 5'd13, 8'h20, 32'h0000_0080));

      repeat (2) @(posedge clk);
      #1 init = 1'b0;
      @(negedge clk) rst = 1'b0;
      chk("reset req_ready", {31'h0, req_ready}, 32'h1);
      chk("reset wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("reset mem_enabled", {31'h0, mem_enabled}, 32'h0);
      chk("reset mem_state", {29'h0, mem_state}, 32'h0);
      chk("reset wb_data", wb_data, 32'h0);
      chk("reset exc", {27'h0, exc_valid, exc_cause}, 32'h0);

      foreach (vecs[k]) run_vec(k, vecs[k]);

      // Fault response held by writeback back-pressure.
      wb_ready = 1'b0;
      start(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd7);
      for (int c = 0; c < 5; c++) begin
         chk("stall fault valid/ready", {30'h0, wb_valid, req_ready}, 32'h2);
         chk("stall fault exc", {27'h0, exc_valid, exc_cause}, {27'h0, 1'b1, 4'd5});
         chk("stall fault tval", exc_tval, 32'h1000);
         chk("stall fault we/rd", {26'h0, wb_we, wb_rd}, {26'h0, 1'b0, 5'd7});
         @(posedge clk); #1;
      end
      wb_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall fault release", {30'h0, wb_valid, req_ready}, 32'h1);

      // Load response held by back-pressure.
      wb_ready = 1'b0;
      start(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd9);
      repeat (2) @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
         chk("stall load valid/ready", {30'h0, wb_valid, req_ready}, 32'h2);
         chk("stall load data", wb_data, 32'h80FF_0000);
         chk("stall load we/exc", {30'h0, wb_we, exc_valid}, 32'h2);
         @(posedge clk); #1;
      end
      wb_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall load release", {30'h0, wb_valid, req_ready}, 32'h1);

      // Reset lands while a store is in ACCESS.
      start(1'b0, 1'b1, 3'b010, 32'h28, 32'hCAFE_BABE, 5'd3);
      chk("rst store in access", {29'h0, mem_state}, 32'h3);
      rst = 1'b1;
      #1;
      chk("rst gates enables", {29'h0, mem_enabled, mem_load_enable, mem_store_enable}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst idle next", {30'h0, wb_valid, req_ready}, 32'h1);
      chk("rst outputs clear", {26'h0, wb_we, exc_valid, mem_enabled, mem_state}, 32'h0);
      chk("rst mem untouched", mem[10], 32'h0102_0304);
      begin
         int pulses = 0;
         for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (wb_valid) pulses++;
         end
         chk("rst no stale response", 32'(pulses), 32'h0);
      end
      run_vec(100, vld(3'b010, 32'h28, 5'd14, 8'h08, 32'h0102_0304));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
